// File: rtl/biriscv_defs.sv
// biriscv_defs: shared encodings for the biriscv FENCE.I controller
package biriscv_defs;
  typedef enum logic [2:0] {
    FENCEI_IDLE     = 3'd0,
    FENCEI_DRAIN    = 3'd1,
    FENCEI_FLUSH    = 3'd2,
    FENCEI_WAIT     = 3'd3,
    FENCEI_REDIRECT = 3'd4
  } fencei_state_e;
  localparam logic [31:0] FENCEI_PC_INC = 32'd4;
endpackage

// File: rtl/biriscv_fencei_ctrl.sv
// biriscv_fencei_ctrl: sequences FENCE.I - drain in-flight fetches, flush icache,
// wait for flush completion (with timeout), then redirect the frontend.
module biriscv_fencei_ctrl
  import biriscv_defs::*;
#(
  parameter int OUTST_W   = 2,
  parameter int TIMEOUT_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        fencei_req_i,
  input  logic [31:0] fencei_pc_i,
  input  logic [1:0]  fencei_priv_i,
  input  logic        abort_i,
  input  logic        icache_rd_i,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic        icache_flush_done_i,
  output logic        hold_flag_o,
  output logic        icache_flush_o,
  output logic        branch_request_o,
  output logic [31:0] branch_pc_o,
  output logic [1:0]  branch_priv_o,
  output logic        fencei_ack_o,
  output logic        busy_o,
  output logic        timeout_o
);
  fencei_state_e state_q, state_d;
  logic [OUTST_W-1:0]   outst_q, outst_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [31:0]          pc_q, pc_d;
  logic [1:0]           priv_q, priv_d;
  logic hold_q, hold_d, flush_q, flush_d, br_q, br_d, tmo_hit_q, tmo_hit_d;
  logic inc, dec, accept_req, expire;
  assign inc     = icache_rd_i & icache_accept_i;
  assign dec     = icache_valid_i;
  assign tmo_inc = tmo_q + 1'b1;
  // WAIT lasts at most 2^TIMEOUT_W-1 cycles: expire on the last one
  assign expire  = (state_q == FENCEI_WAIT) && (&tmo_inc);
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FENCEI_IDLE;
      outst_q   <= '0;
      tmo_q     <= '0;
      pc_q      <= '0;
      priv_q    <= '0;
      hold_q    <= 1'b0;
      flush_q   <= 1'b0;
      br_q      <= 1'b0;
      tmo_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      outst_q   <= outst_d;
      tmo_q     <= tmo_d;
      pc_q      <= pc_d;
      priv_q    <= priv_d;
      hold_q    <= hold_d;
      flush_q   <= flush_d;
      br_q      <= br_d;
      tmo_hit_q <= tmo_hit_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FENCEI_IDLE:     if (fencei_req_i) state_d = FENCEI_DRAIN;
      FENCEI_DRAIN:    if (outst_q == '0 && !inc) state_d = FENCEI_FLUSH;
      FENCEI_FLUSH:    state_d = FENCEI_WAIT;
      FENCEI_WAIT:     if (icache_flush_done_i || expire) state_d = FENCEI_REDIRECT;
      FENCEI_REDIRECT: state_d = FENCEI_IDLE;
      default:         state_d = FENCEI_IDLE;
    endcase
    if (abort_i) state_d = FENCEI_IDLE;
  end
  // Outputs are registered copies of the next-state decode
  always_comb begin
    accept_req = (state_q == FENCEI_IDLE) && fencei_req_i && !abort_i;
    pc_d       = accept_req ? fencei_pc_i + FENCEI_PC_INC : pc_q;
    priv_d     = accept_req ? fencei_priv_i : priv_q;
    outst_d    = (inc && !dec && !(&outst_q)) ? outst_q + 1'b1 :
                 (dec && !inc && (|outst_q))  ? outst_q - 1'b1 : outst_q;
    tmo_d      = (state_q == FENCEI_WAIT) ? tmo_inc : '0;
    hold_d     = state_d != FENCEI_IDLE;
    flush_d    = state_d == FENCEI_FLUSH;
    br_d       = state_d == FENCEI_REDIRECT;
    tmo_hit_d  = expire && !icache_flush_done_i && !abort_i;
  end
  assign hold_flag_o      = hold_q;
  assign busy_o           = hold_q;
  assign icache_flush_o   = flush_q;
  assign branch_request_o = br_q;
  assign fencei_ack_o     = br_q;
  assign branch_pc_o      = pc_q;
  assign branch_priv_o    = priv_q;
  assign timeout_o        = tmo_hit_q;
endmodule

// File: doc/biriscv_fencei_ctrl.md
BIRISCV_FENCEI_CTRL -- requirements
Module: biriscv_fencei_ctrl

Interface
REQ-001 SHALL have parameter OUTST_W, default 2: width of the outstanding-fetch counter (max 2^OUTST_W-1).
REQ-002 SHALL have parameter TIMEOUT_W, default 10: width of the flush-wait timeout counter (limit 2^TIMEOUT_W-1 cycles).
REQ-003 SHALL have port clk_i  in  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fencei_req_i  in  1  FENCE.I request from execute.
REQ-006 SHALL have port fencei_pc_i  in  32  PC of the FENCE.I instruction.
REQ-007 SHALL have port fencei_priv_i  in  2  privilege level for the restart fetch.
REQ-008 SHALL have port abort_i  in  1  trap or higher-priority redirect that cancels the sequence.
REQ-009 SHALL have port icache_rd_i  in  1  frontend fetch request to the icache.
REQ-010 SHALL have port icache_accept_i  in  1  icache accepted the request.
REQ-011 SHALL have port icache_valid_i  in  1  icache returned a response.
REQ-012 SHALL have port icache_flush_done_i  in  1  icache flush complete.
REQ-013 SHALL have port hold_flag_o  out  1  stalls frontend fetch issue (drives frontend hold_flag_i).
REQ-014 SHALL have port icache_flush_o  out  1  one-cycle icache flush strobe.
REQ-015 SHALL have port branch_request_o  out  1  one-cycle frontend redirect strobe.
REQ-016 SHALL have port branch_pc_o  out  32  restart PC.
REQ-017 SHALL have port branch_priv_o  out  2  restart privilege.
REQ-018 SHALL have port fencei_ack_o  out  1  one-cycle completion strobe.
REQ-019 SHALL have port busy_o  out  1  high whenever state is not IDLE.
REQ-020 SHALL have port timeout_o  out  1  one-cycle strobe when the flush wait times out.

Function
REQ-021 SHALL drive all outputs from registers; no combinational input-to-output path.
REQ-022 SHALL implement states IDLE, DRAIN, FLUSH, WAIT, REDIRECT.
REQ-023 SHALL, in IDLE with fencei_req_i=1 and abort_i=0, capture fencei_pc_i+4 (mod 2^32) and fencei_priv_i, then enter DRAIN.
REQ-024 SHALL assert hold_flag_o in every non-IDLE state; hold_flag_o rises the cycle after the request is captured.
REQ-025 SHALL keep a counter of outstanding fetches: +1 on icache_rd_i&icache_accept_i, -1 on icache_valid_i, unchanged when both occur in the same cycle.
REQ-026 SHALL saturate the counter at its maximum and ignore a decrement at 0.
REQ-027 SHALL leave DRAIN for FLUSH on the first cycle the counter is 0 with no increment pending.
REQ-028 SHALL assert icache_flush_o for exactly one cycle in FLUSH, then enter WAIT.
REQ-029 SHALL, in WAIT, enter REDIRECT when icache_flush_done_i=1, or when the timeout counter reaches its limit (pulse timeout_o).
REQ-030 SHALL, in REDIRECT, pulse branch_request_o and fencei_ack_o together for one cycle with branch_pc_o/branch_priv_o valid, then return to IDLE.
REQ-031 SHALL give abort_i priority in every state: it returns the FSM to IDLE next cycle with no redirect, no ack, and hold released.
REQ-032 SHALL ignore fencei_req_i while busy_o=1.
REQ-033 SHALL ignore icache_flush_done_i outside WAIT.
REQ-034 SHALL clear the timeout counter on every entry to WAIT.

Reset
REQ-035 SHALL, on rst_n low, asynchronously force IDLE, zero both counters, branch_pc_o=0, branch_priv_o=0, and every 1-bit output to 0, including mid-sequence.
REQ-036 SHALL leave reset cleanly on the first rising edge after rst_n rises, with no spurious strobe.

Structure
REQ-037 SHALL define the state encoding constants in the shared biriscv_defs package.
REQ-038 SHALL be a single flat module with no sub-modules, instantiated beside biriscv_frontend.

Verification
REQ-039 SHALL cover the basic sequence: req pc=0x80000100, 0 outstanding, flush_done 3 cycles after flush -> flush at cycle 2, branch_request_o with pc 0x80000104 and ack on the same cycle.
REQ-040 SHALL cover drain: 2 accepted fetches outstanding at request, valid returns at +4 and +6 -> icache_flush_o is not asserted before cycle +7.
REQ-041 SHALL cover abort in WAIT: abort_i=1 -> IDLE next cycle, no branch_request_o, no ack, hold_flag_o=0.
REQ-042 SHALL cover timeout: flush_done never asserted, TIMEOUT_W=4 -> timeout_o after 15 WAIT cycles, then redirect and ack.
REQ-043 SHALL cover wrap-around: pc=0xFFFFFFFC -> branch_pc_o=0x00000000.
REQ-044 SHALL cover reset mid-sequence: rst_n low in DRAIN -> all outputs 0 immediately; a new request after reset completes normally.
